// File: rtl/valid_table_nway.sv
// ---------------------------------------------------------------------------
// valid_table_nway
//
// Per-way valid-bit table for a set-associative cache, kept beside the
// tag/data RAMs. Holds DEPTH sets x WAYS valid bits.
//   - Registered read with 1-cycle latency. The result holds while rd_en_i=0.
//   - Per-way masked writes.
//   - A flush FSM (IDLE -> SWEEP -> DONE) invalidates one set per cycle.
//   - Reports the lowest invalid way of the last read set for refill.
//
// The table is built from flops, not block RAM, because reset must clear
// every bit asynchronously.
//
// Build option:
//   VALID_WR_BYPASS_EN  defined   -> write-first on a same-index read/write
//                       undefined -> read-first (returns the pre-write bits)
//
// Ports:
//   clk            clock
//   rst            asynchronous reset, active-high
//   rd_en_i        read strobe
//   rd_index_i     read set index
//   wr_en_i        write strobe (ignored while a flush is in progress)
//   wr_index_i     write set index
//   wr_way_mask_i  ways to update
//   wr_valid_i     value written to every masked way
//   flush_req_i    start a whole-table invalidate (ignored while busy)
//   flush_busy_o   sweep in progress (SWEEP or DONE)
//   flush_done_o   1-cycle pulse when the sweep completes
//   rd_valid_o     registered valid vector of the read set
//   rd_free_vld_o  at least one way in rd_valid_o is invalid
//   rd_free_way_o  lowest-numbered invalid way, 0 if none
// ---------------------------------------------------------------------------
module valid_table_nway #(
  parameter int WAYS  = 2,
  parameter int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_index_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_index_i,
  input  logic [WAYS-1:0]  wr_way_mask_i,
  input  logic             wr_valid_i,
  input  logic             flush_req_i,
  output logic             flush_busy_o,
  output logic             flush_done_o,
  output logic [WAYS-1:0]  rd_valid_o,
  output logic             rd_free_vld_o,
  output logic [WAY_W-1:0] rd_free_way_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                      state_reg, state_next;
  logic [IDX_W-1:0]            cnt_reg;
  logic [DEPTH-1:0][WAYS-1:0]  table_w;
  logic [WAYS-1:0]             rd_valid_reg;
  logic [WAYS-1:0]             rd_word;
  logic [WAYS-1:0]             rd_next;
  logic                        in_idle;
  logic                        in_sweep;
  logic                        wr_act;
  logic                        last_set;

  assign in_idle  = (state_reg == ST_IDLE);
  assign in_sweep = (state_reg == ST_SWEEP);
  // Writes are only accepted in IDLE; during a flush they are dropped.
  assign wr_act   = in_idle && wr_en_i;
  assign last_set = (cnt_reg == IDX_W'(DEPTH - 1));

  // ---------------------------------------------------------------------
  // Flush FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (flush_req_i) state_next = ST_SWEEP;
      ST_SWEEP: if (last_set)    state_next = ST_DONE;
      ST_DONE:                   state_next = ST_IDLE;
      default:                   state_next = ST_IDLE;
    endcase
  end

  // The sweep counter stops at DEPTH-1 instead of wrapping; it is reloaded
  // with 0 when the next flush starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (in_idle && flush_req_i) begin
      cnt_reg <= '0;
    end else if (in_sweep && !last_set) begin
      cnt_reg <= cnt_reg + IDX_W'(1);
    end
  end

  assign flush_busy_o = !in_idle;
  assign flush_done_o = (state_reg == ST_DONE);

  // ---------------------------------------------------------------------
  // Valid storage: one register per set. The sweep and writes are never
  // active together because writes are gated to IDLE.
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_set
    logic [WAYS-1:0] bits_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        bits_reg <= '0;
      end else if (in_sweep && (cnt_reg == IDX_W'(gi))) begin
        bits_reg <= '0;
      end else if (wr_act && (wr_index_i == IDX_W'(gi))) begin
        bits_reg <= (bits_reg & ~wr_way_mask_i) |
                    (wr_valid_i ? wr_way_mask_i : '0);
      end
    end

    assign table_w[gi] = bits_reg;
  end

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  assign rd_word = table_w[rd_index_i];

`ifdef VALID_WR_BYPASS_EN
  // Write-first: forward the masked write data onto a same-index read.
  always_comb begin
    rd_next = rd_word;
    if (wr_act && (wr_index_i == rd_index_i)) begin
      rd_next = (rd_word & ~wr_way_mask_i) |
                (wr_valid_i ? wr_way_mask_i : '0);
    end
  end
`else
  // Read-first: the stored bits before this cycle's write are returned.
  assign rd_next = rd_word;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_reg <= '0;
    end else if (rd_en_i) begin
      // A read during a flush reports an all-invalid set.
      rd_valid_reg <= in_idle ? rd_next : '0;
    end
  end

  assign rd_valid_o = rd_valid_reg;

  // ---------------------------------------------------------------------
  // Free-way reporting (combinational from the registered read)
  // ---------------------------------------------------------------------
  assign rd_free_vld_o = ~&rd_valid_reg;

  always_comb begin
    logic found;
    found         = 1'b0;
    rd_free_way_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!rd_valid_reg[w] && !found) begin
        rd_free_way_o = WAY_W'(w);
        found         = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_valid_table_nway.sv
// ---------------------------------------------------------------------------
// tb_valid_table_nway
//
// Scoreboard bench for valid_table_nway (WAYS=4, DEPTH=16). The driver keeps
// a plain array model of the table plus the flush busy window. It pushes
// expected read results and flush-done cycles into queues. A negedge monitor
// pops the queues and compares them whenever the DUT presents a read result
// or a done pulse. It also checks flush_busy_o in every cycle.
// ---------------------------------------------------------------------------
module tb_valid_table_nway;
  localparam int WAYS  = 4;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  localparam int WAY_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             rd_en = 1'b0;
  logic [IDX_W-1:0] rd_index = '0;
  logic             wr_en = 1'b0;
  logic [IDX_W-1:0] wr_index = '0;
  logic [WAYS-1:0]  wr_mask = '0;
  logic             wr_valid = 1'b0;
  logic             flush_req = 1'b0;
  logic             flush_busy_o;
  logic             flush_done_o;
  logic [WAYS-1:0]  rd_valid_o;
  logic             rd_free_vld_o;
  logic [WAY_W-1:0] rd_free_way_o;

  valid_table_nway #(.WAYS(WAYS), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .rd_en_i       (rd_en),
    .rd_index_i    (rd_index),
    .wr_en_i       (wr_en),
    .wr_index_i    (wr_index),
    .wr_way_mask_i (wr_mask),
    .wr_valid_i    (wr_valid),
    .flush_req_i   (flush_req),
    .flush_busy_o  (flush_busy_o),
    .flush_done_o  (flush_done_o),
    .rd_valid_o    (rd_valid_o),
    .rd_free_vld_o (rd_free_vld_o),
    .rd_free_way_o (rd_free_way_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [WAYS-1:0] model [DEPTH];
  logic [WAYS-1:0] exp_q [$];
  int              done_q [$];
  int              busy_start = 1;
  int              busy_end   = 0;
  int              cyc        = 0;
  bit              rd_pend    = 1'b0;
  int              checks     = 0;
  int              errors     = 0;

  function automatic bit model_busy(int c);
    return (c >= busy_start) && (c <= busy_end);
  endfunction

  function automatic int lowest_zero(logic [WAYS-1:0] v);
    for (int w = 0; w < WAYS; w++) begin
      if (!v[w]) return w;
    end
    return 0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_pend <= rd_en;
  end

  // Monitor: decoupled from the driver, consumes the expectation queues.
  always @(negedge clk) begin
    logic [WAYS-1:0] e;
    chk("busy", {31'd0, flush_busy_o}, {31'd0, model_busy(cyc)});
    if (flush_done_o) begin
      if (done_q.size() == 0) fail_event("done_extra");
      else chk("done_cycle", cyc, done_q.pop_front());
    end else if (done_q.size() > 0 && cyc > done_q[0]) begin
      chk("done_missing", cyc, done_q.pop_front());
    end
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        fail_event("rd_extra");
      end else begin
        e = exp_q.pop_front();
        $display("read cycle %0d: rd_valid=%b expected %b", cyc, rd_valid_o, e);
        chk("rd_valid", {28'd0, rd_valid_o}, {28'd0, e});
        chk("free_vld", {31'd0, rd_free_vld_o}, {31'd0, ~&e});
        chk("free_way", {30'd0, rd_free_way_o}, lowest_zero(e));
      end
    end
  end

  // One clock of stimulus; updates the model with the effect of this cycle.
  task automatic step(bit rd, int ri, bit wr, int wi, logic [WAYS-1:0] m,
                      bit val, bit fl);
    logic [WAYS-1:0] e;
    bit b;
    b         = model_busy(cyc);
    rd_en     = rd;
    rd_index  = ri[IDX_W-1:0];
    wr_en     = wr;
    wr_index  = wi[IDX_W-1:0];
    wr_mask   = m;
    wr_valid  = val;
    flush_req = fl;
    if (rd) begin
      if (b) begin
        e = '0;
      end else begin
        e = model[ri];
`ifdef VALID_WR_BYPASS_EN
        if (wr && wi == ri) e = val ? (e | m) : (e & ~m);
`endif
      end
      exp_q.push_back(e);
    end
    if (wr && !b) model[wi] = val ? (model[wi] | m) : (model[wi] & ~m);
    if (fl && !b) begin
      busy_start = cyc + 1;
      busy_end   = cyc + DEPTH + 1;
      done_q.push_back(cyc + DEPTH + 1);
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) step(1, i, 0, 0, '0, 0, 0);
    idle(1);
  endtask

  // Reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    idle(1);
    @(negedge clk);
    #1;
    rst        = 1'b1;
    busy_start = 1;
    busy_end   = 0;
    done_q.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    #1;
    chk("rst_rd_valid", {28'd0, rd_valid_o}, 32'd0);
    chk("rst_busy", {31'd0, flush_busy_o}, 32'd0);
    chk("rst_done", {31'd0, flush_done_o}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic with frequent same-index collisions and rare flushes.
    for (int n = 0; n < 400; n++) begin
      int ri, wi;
      ri = ($urandom % 2) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1);
      wi = ($urandom % 2) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1);
      step($urandom % 2, ri, $urandom % 2, wi, WAYS'($urandom),
           $urandom % 2, ($urandom % 64) == 0);
    end
    idle(DEPTH + 3);

    // T1: mid-cycle reset clears outputs, then every set reads 0.
    do_reset();
    read_all();

    // T2: masked write then reads.
    step(0, 0, 1, 5, 4'b0101, 1, 0);
    step(1, 5, 0, 0, '0, 0, 0);
    step(1, 6, 0, 0, '0, 0, 0);
    idle(1);

    // T3: same-cycle read/write collision on set 9.
    step(1, 9, 1, 9, 4'b0010, 1, 0);
    step(1, 9, 0, 0, '0, 0, 0);
    idle(1);

    // T4/T5: fill, flush, read during busy, dropped write and second request.
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, i, '1, 1, 0);
    step(0, 0, 0, 0, '0, 0, 1);
    step(1, DEPTH - 1, 0, 0, '0, 0, 0);
    step(0, 0, 1, 3, '1, 1, 1);
    idle(DEPTH + 2);
    read_all();

    // T6: reset in the middle of a sweep.
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, i, 4'b1011, 1, 0);
    step(0, 0, 0, 0, '0, 0, 1);
    idle(DEPTH / 2);
    do_reset();
    idle(DEPTH + 3);
    read_all();

    idle(3);
    chk("done_q_drained", done_q.size(), 32'd0);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
